// File: rtl/cache_line_fill_engine.sv
// Cache miss-service engine: optionally writes back a dirty victim line, then
// reads the requested line word by word from RAM and returns it assembled.
module cache_line_fill_engine #(
  parameter  int ADDR_W         = 15,
  parameter  int DATA_W         = 32,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int RAM_LAT        = 1,
  localparam int OFS_W          = $clog2(WORDS_PER_LINE),
  localparam int LINE_W         = DATA_W * WORDS_PER_LINE,
  localparam int LA_W           = ADDR_W - OFS_W
) (
  input  logic              globalclock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LA_W-1:0]   req_line_addr,
  input  logic              req_wb,
  input  logic [LA_W-1:0]   req_wb_line_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [LA_W-1:0]   fill_line_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, WB, RD, WAIT, FILL} state_t;

  state_t              state_q, state_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [OFS_W-1:0]    cap_ofs_q, cap_ofs_d;
  logic [RAM_LAT-1:0]  vld_q, vld_d;
  logic [LA_W-1:0]     line_q, line_d;
  logic [LA_W-1:0]     wb_line_q, wb_line_d;
  logic [LINE_W-1:0]   wb_data_q, wb_data_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic                issue;
  logic                capture;
  logic                last_ofs;
  logic                last_cap;

  assign fill_line_addr = line_q;
  assign fill_data      = fill_q;

  always_comb begin
    state_d   = state_q;
    ofs_d     = ofs_q;
    cap_ofs_d = cap_ofs_q;
    vld_d     = vld_q;
    line_d    = line_q;
    wb_line_d = wb_line_q;
    wb_data_d = wb_data_q;
    fill_d    = fill_q;
    issue     = 1'b0;
    req_ready  = 1'b0;
    fill_valid = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    capture  = vld_q[RAM_LAT-1];
    last_ofs = (ofs_q == OFS_W'(WORDS_PER_LINE - 1));
    last_cap = (cap_ofs_q == OFS_W'(WORDS_PER_LINE - 1));

    // Returning words arrive in issue order, so a running slot index suffices.
    if (capture) begin
      fill_d[cap_ofs_q*DATA_W +: DATA_W] = ram_rdata;
      cap_ofs_d = cap_ofs_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d    = req_line_addr;
          wb_line_d = req_wb_line_addr;
          wb_data_d = req_wb_data;
          ofs_d     = '0;
          cap_ofs_d = '0;
          state_d   = req_wb ? WB : RD;
        end
      end
      WB: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {wb_line_q, ofs_q};
        ram_wdata = wb_data_q[ofs_q*DATA_W +: DATA_W];
        ofs_d     = ofs_q + 1'b1;
        if (last_ofs) state_d = RD;
      end
      RD: begin
        ram_en   = 1'b1;
        ram_addr = {line_q, ofs_q};
        issue    = 1'b1;
        ofs_d    = ofs_q + 1'b1;
        if (last_ofs) state_d = WAIT;
      end
      WAIT: begin
        if (capture && last_cap) state_d = FILL;
      end
      FILL: begin
        fill_valid = 1'b1;
        if (fill_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Each bit marks a read in flight; the top bit lines up with its data.
    vld_d[0] = issue;
    for (int i = 1; i < RAM_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge globalclock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ofs_q     <= '0;
      cap_ofs_q <= '0;
      vld_q     <= '0;
      line_q    <= '0;
      wb_line_q <= '0;
      wb_data_q <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      ofs_q     <= ofs_d;
      cap_ofs_q <= cap_ofs_d;
      vld_q     <= vld_d;
      line_q    <= line_d;
      wb_line_q <= wb_line_d;
      wb_data_q <= wb_data_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// Bench for cache_line_fill_engine: a RAM plus cycle-schedule reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_cache_line_fill_engine;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int WPL    = 4;
  localparam int LAT    = 3;
  localparam int LA_W   = 13;
  localparam int LINE_W = 128;

  logic              globalclock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [LA_W-1:0]   req_line_addr;
  logic              req_wb;
  logic [LA_W-1:0]   req_wb_line_addr;
  logic [LINE_W-1:0] req_wb_data;
  logic              fill_valid;
  logic              fill_ready;
  logic [LA_W-1:0]   fill_line_addr;
  logic [LINE_W-1:0] fill_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int checks = 0;
  int failures = 0;

  cache_line_fill_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .RAM_LAT(LAT)
  ) dut (
    .globalclock(globalclock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_line_addr(req_line_addr), .req_wb(req_wb),
    .req_wb_line_addr(req_wb_line_addr), .req_wb_data(req_wb_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_line_addr(fill_line_addr), .fill_data(fill_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 globalclock = ~globalclock;

  // RAM contents: unwritten words read as a fixed function of their address.
  logic [31:0] mem [0:32767];
  bit          written [0:32767];

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } rd_t;
  rd_t rd_q[$];
  rd_t e;

  bit              m_busy;
  int              m_t;
  bit              m_wb;
  logic [LA_W-1:0] m_line;
  logic [LA_W-1:0] m_wbline;
  logic [127:0]    m_wbdata;

  logic              exp_en, exp_we, exp_fv;
  logic [14:0]       exp_addr;
  logic [31:0]       exp_wdata;
  logic [127:0]      exp_line;
  logic [1:0]        ofs;
  int                rd_start, fill_start;

  int           fc, seen;
  logic [14:0]  fa, la;
  logic [127:0] saved;

  function automatic logic [31:0] mem_rd(input logic [14:0] a);
    return written[a] ? mem[a] : (32'hA500_0000 | 32'(a));
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sendReq(input logic [12:0] line, input logic wb, input logic [12:0] wbline,
                         input logic [127:0] wbdata, input logic fr,
                         output int fill_cycle, output logic [14:0] first_addr,
                         output logic [14:0] last_addr);
    @(posedge globalclock); #1;
    req_valid = 1'b1; req_line_addr = line; req_wb = wb;
    req_wb_line_addr = wbline; req_wb_data = wbdata; fill_ready = fr;
    @(posedge globalclock); #1;
    req_valid = 1'b0; req_line_addr = 13'($urandom); req_wb = 1'($urandom);
    req_wb_line_addr = 13'($urandom); req_wb_data = {$urandom, $urandom, $urandom, $urandom};
    fill_cycle = 0; first_addr = '0; last_addr = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge globalclock);
      if (c == (wb ? 5 : 1)) first_addr = ram_addr;
      if (c == (wb ? 8 : 4)) last_addr = ram_addr;
      if (fill_valid) begin
        fill_cycle = c;
        break;
      end
    end
    if (fill_cycle == 0) checkOutput("fill_timeout", 128'(0), 128'(1));
  endtask

  task automatic applyStimulus();
    @(posedge globalclock); #1;
    reset            = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    req_valid        = ($urandom_range(0, 2) == 0);
    req_line_addr    = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom);
    req_wb           = 1'($urandom_range(0, 1));
    req_wb_line_addr = 13'($urandom);
    req_wb_data      = {$urandom, $urandom, $urandom, $urandom};
    fill_ready       = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_line_addr = '0; req_wb = 1'b0;
    req_wb_line_addr = '0; req_wb_data = '0; fill_ready = 1'b0; ram_rdata = '0;
    m_busy = 0; m_t = 0; m_wb = 0; m_line = '0; m_wbline = '0; m_wbdata = '0;
    fork
      // Reference model and RAM: evaluated mid-cycle when all outputs are settled.
      forever begin
        @(negedge globalclock);
        if (!reset) begin
          m_busy = 0;
          rd_q.delete();
          ram_rdata = $urandom;
          checkOutput("rst_req_ready", 128'(req_ready), 128'(1));
          checkOutput("rst_fill_valid", 128'(fill_valid), 128'(0));
          checkOutput("rst_ram_en", 128'(ram_en), 128'(0));
          checkOutput("rst_ram_addr", 128'(ram_addr), 128'(0));
        end else begin
          exp_en = 0; exp_we = 0; exp_fv = 0; exp_addr = '0; exp_wdata = '0;
          rd_start   = m_wb ? 5 : 1;
          fill_start = rd_start + WPL + LAT;
          if (m_busy) begin
            if (m_wb && m_t <= 4) begin
              ofs = 2'(m_t - 1);
              exp_en = 1; exp_we = 1; exp_addr = {m_wbline, ofs};
              exp_wdata = m_wbdata[32*(m_t-1) +: 32];
            end else if (m_t >= rd_start && m_t < rd_start + 4) begin
              ofs = 2'(m_t - rd_start);
              exp_en = 1; exp_addr = {m_line, ofs};
            end
            exp_fv = (m_t >= fill_start);
          end
          checkOutput("req_ready", 128'(req_ready), 128'(!m_busy));
          checkOutput("ram_en", 128'(ram_en), 128'(exp_en));
          if (exp_en) begin
            checkOutput("ram_we", 128'(ram_we), 128'(exp_we));
            checkOutput("ram_addr", 128'(ram_addr), 128'(exp_addr));
            if (exp_we) checkOutput("ram_wdata", 128'(ram_wdata), 128'(exp_wdata));
          end
          checkOutput("fill_valid", 128'(fill_valid), 128'(exp_fv));
          if (exp_fv) begin
            for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = mem_rd({m_line, 2'(k)});
            checkOutput("fill_line_addr", 128'(fill_line_addr), 128'(m_line));
            checkOutput("fill_data", fill_data, exp_line);
          end
          if (ram_en && ram_we) begin
            mem[ram_addr] = ram_wdata;
            written[ram_addr] = 1;
          end
          e.v = ram_en && !ram_we;
          e.d = mem_rd(ram_addr);
          rd_q.push_back(e);
          if (rd_q.size() > LAT) begin
            e = rd_q.pop_front();
            ram_rdata = e.v ? e.d : $urandom;
          end else begin
            ram_rdata = $urandom;
          end
          if (!m_busy) begin
            if (req_valid) begin
              m_busy = 1; m_t = 1; m_wb = req_wb; m_line = req_line_addr;
              m_wbline = req_wb_line_addr; m_wbdata = req_wb_data;
            end
          end else if (exp_fv && fill_ready) begin
            m_busy = 0;
          end else begin
            m_t++;
          end
        end
      end

      begin
        repeat (2) @(posedge globalclock);
        #1;
        checkOutput("t1_req_ready", 128'(req_ready), 128'(1));
        checkOutput("t1_fill_valid", 128'(fill_valid), 128'(0));
        checkOutput("t1_ram_en", 128'(ram_en), 128'(0));
        checkOutput("t1_ram_addr", 128'(ram_addr), 128'(0));
        reset = 1'b1;

        sendReq(13'h1E0C, 1'b0, 13'h0, 128'h0, 1'b1, fc, fa, la);
        checkOutput("t2_fill_cycle", 128'(fc), 128'(8));
        checkOutput("t2_first_addr", 128'(fa), 128'(15'h7830));
        checkOutput("t2_last_addr", 128'(la), 128'(15'h7833));
        checkOutput("t2_fill_data", fill_data, 128'hA5007833_A5007832_A5007831_A5007830);
        checkOutput("t2_fill_line", 128'(fill_line_addr), 128'(13'h1E0C));

        sendReq(13'h0002, 1'b1, 13'h0001, 128'hD0000003_D0000002_D0000001_D0000000, 1'b1, fc, fa, la);
        checkOutput("t3_fill_cycle", 128'(fc), 128'(12));
        checkOutput("t3_first_rd_addr", 128'(fa), 128'(15'h0008));
        checkOutput("t3_last_rd_addr", 128'(la), 128'(15'h000B));
        for (int k = 0; k < 4; k++)
          checkOutput("t3_wb_word", 128'(mem[15'(4 + k)]), 128'(32'hD000_0000 + 32'(k)));
        checkOutput("t3_fill_data", fill_data, 128'hA500000B_A500000A_A5000009_A5000008);

        sendReq(13'h0ABC, 1'b0, 13'h0, 128'h0, 1'b0, fc, fa, la);
        saved = fill_data;
        checkOutput("t4_fill_data", saved, 128'hA5002AF3_A5002AF2_A5002AF1_A5002AF0);
        repeat (3) begin
          @(posedge globalclock); #1;
          req_valid = 1'b1; req_line_addr = 13'($urandom);
          @(negedge globalclock);
          checkOutput("t4_hold_valid", 128'(fill_valid), 128'(1));
          checkOutput("t4_hold_data", fill_data, saved);
          checkOutput("t4_busy_ready", 128'(req_ready), 128'(0));
        end
        @(posedge globalclock); #1;
        req_valid = 1'b0; fill_ready = 1'b1;
        @(negedge globalclock);
        checkOutput("t4_last_fill", 128'(fill_valid), 128'(1));
        @(posedge globalclock); #1;
        checkOutput("t4_idle_ready", 128'(req_ready), 128'(1));
        checkOutput("t4_idle_fill", 128'(fill_valid), 128'(0));

        @(posedge globalclock); #1;
        req_valid = 1'b1; req_line_addr = 13'h0100; req_wb = 1'b0;
        @(posedge globalclock); #1;
        req_valid = 1'b0;
        @(posedge globalclock); #1;
        @(posedge globalclock); #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_abort_ram_en", 128'(ram_en), 128'(0));
        checkOutput("t5_abort_ready", 128'(req_ready), 128'(1));
        @(posedge globalclock); #1;
        reset = 1'b1;
        seen = 0;
        repeat (15) begin
          @(negedge globalclock);
          if (fill_valid) seen = 1;
        end
        checkOutput("t5_no_fill", 128'(seen), 128'(0));
        sendReq(13'h0100, 1'b0, 13'h0, 128'h0, 1'b1, fc, fa, la);
        checkOutput("t5_retry_cycle", 128'(fc), 128'(8));
        checkOutput("t5_retry_data", fill_data, 128'hA5000403_A5000402_A5000401_A5000400);

        sendReq(13'h1FFF, 1'b0, 13'h0, 128'h0, 1'b1, fc, fa, la);
        checkOutput("t6_last_addr", 128'(la), 128'(15'h7FFF));
        checkOutput("t6_fill_cycle", 128'(fc), 128'(8));
        checkOutput("t6_fill_data", fill_data, 128'hA5007FFF_A5007FFE_A5007FFD_A5007FFC);

        for (int i = 0; i < 3000; i++) applyStimulus();
        @(posedge globalclock); #1;
        reset = 1'b1; req_valid = 1'b0; fill_ready = 1'b1;
        repeat (20) @(posedge globalclock);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
